// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (counters, syncs, data enable, line/frame markers)
// Next position and all decodes are computed together so every registered output describes the same pixel.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_check
    $error("video_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // One extra bit so sync-end bounds equal to 2^CW still compare correctly.
  localparam logic [CW:0] H_ACT_END  = (CW + 1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW + 1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW + 1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW + 1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW + 1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (H_POL != 0);
  localparam logic VS_ACT = (V_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] sx_q, sx_d;
  logic [CW-1:0] sy_q, sy_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [CW:0]   sx_w, sy_w;

  always_comb begin
    state_d       = IDLE;
    sx_d          = '0;
    sy_d          = '0;
    de_d          = 1'b0;
    hsync_d       = ~HS_ACT;
    vsync_d       = ~VS_ACT;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    sx_w          = '0;
    sy_w          = '0;
    if (locked) begin
      state_d = RUN;
      // Entering RUN from IDLE keeps sx_d/sy_d at zero: a relock always restarts the frame.
      if (state_q == RUN) begin
        if (sx_q == H_LAST) begin
          sx_d = '0;
          sy_d = (sy_q == V_LAST) ? '0 : sy_q + CW'(1);
        end else begin
          sx_d = sx_q + CW'(1);
          sy_d = sy_q;
        end
      end
      sx_w          = {1'b0, sx_d};
      sy_w          = {1'b0, sy_d};
      de_d          = (sx_w < H_ACT_END) && (sy_w < V_ACT_END);
      hsync_d       = (sx_w >= H_SYNC_BEG && sx_w < H_SYNC_END) ? HS_ACT : ~HS_ACT;
      vsync_d       = (sy_w >= V_SYNC_BEG && sy_w < V_SYNC_END) ? VS_ACT : ~VS_ACT;
      line_start_d  = (sx_d == '0);
      frame_start_d = (sx_d == '0) && (sy_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sx_q          <= '0;
      sy_q          <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

- Generates raster timing for the DVI/HDMI video path: horizontal/vertical counters, sync pulses, data-enable and frame/line markers.
- Clocked by the pixel clock and gated by the pixel-clock lock indication, both from the pixel clock divider.
- Its outputs feed the pixel-fetch and TMDS encoder stages.
- Default parameters give 640x480 @ 60 Hz (800x525 total, 25.175 MHz nominal pixel clock).

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CW, 12, counter width; elaboration error if 2^CW < H_TOTAL or 2^CW < V_TOTAL

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- locked  in  1  pixel-clock lock; already synchronized to clk by the clock divider
- sx  out  CW  current horizontal position
- sy  out  CW  current vertical position
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- de  out  1  data enable (visible pixel)
- line_start  out  1  high for the single cycle where sx == 0
- frame_start  out  1  high for the single cycle where sx == 0 and sy == 0

## Operation

- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_ parameters.
- Order within each line and each frame: active, front porch, sync, back porch.
- Two-state FSM:
  - IDLE to RUN: when locked is sampled high.
  - RUN to IDLE: when locked is sampled low.
  - rst_n low forces IDLE.
- IDLE outputs:
  - sx = sy = 0, de = 0, line_start = frame_start = 0.
  - hsync = ~H_POL, vsync = ~V_POL (both inactive).
- RUN counting:
  - sx increments by 1 each cycle.
  - At sx == H_TOTAL-1: sx becomes 0 and sy increments.
  - At sx == H_TOTAL-1 and sy == V_TOTAL-1: both become 0.
  - Counters never take values ≥ the respective total.
- Alignment: all outputs are registered and mutually aligned. In any RUN cycle, hsync/vsync/de/line_start/frame_start describe the position (sx, sy) presented in that same cycle.
- Decodes in RUN:
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - hsync = H_POL when H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC, for whole lines (changes coincide with sx == 0); otherwise ~V_POL.
- Lock loss in RUN, at any position: the current frame is abandoned.
- Relock: always restarts the frame at (0,0). Position is never resumed.
- Reset mid-operation: identical to lock loss, except it is asynchronous.

## Timing

- Reset values: every output equals its IDLE value, applied asynchronously when rst_n falls.
- Release of rst_n is synchronous to clk; the first possible RUN transition is on the first edge after release with locked high.
- Startup latency: locked first sampled high at edge k, so outputs after edge k show (0,0) with de = 1, line_start = 1, frame_start = 1.
- Shutdown latency: locked sampled low at edge k, so outputs after edge k carry IDLE values. No partial-line completion.
- Periods with defaults:
  - line_start every 800 cycles.
  - frame_start every 420000 cycles.
  - hsync active 96 cycles at sx 656..751.
  - vsync active 1600 cycles, sy 490..491.
- No backpressure; the block free-runs while locked is high.

## Test plan

- Reset and idle:
  - Assert rst_n low mid-count with no clock edge: outputs go to sx = 0, sy = 0, de = 0, hsync = vsync = 1 immediately.
  - Release rst_n with locked = 0 for 200 cycles: outputs stay idle.
- Startup: raise locked before edge k. After edge k: sx = 0, sy = 0, de = 1, frame_start = 1, line_start = 1. After edge k+1: sx = 1, frame_start = 0.
- Line timing (defaults):
  - Per line: de high exactly 640 consecutive cycles; hsync low exactly at sx 656..751; line_start period 800.
  - Wrap: sx 799 is followed by sx 0 with sy+1.
- Frame timing (defaults):
  - frame_start period 420000 cycles.
  - vsync low 1600 cycles, starting at (0,490).
  - de never high for sy ≥ 480.
  - (799,524) is followed by (0,0) with frame_start = 1.
- Lock loss: drop locked at (300,100).
  - Next cycle: idle values.
  - Raise locked 50 cycles later: restart at (0,0) with frame_start = 1.
- Parameter override and polarity:
  - Set H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1.
  - line period = 8 cycles, frame period = 48 cycles, hsync high at sx 5..6, vsync high for sy = 4.
